tabla_scan_ctrl: RTL and testbench

Sequencer that exhaustively sweeps input vectors through the truth-table evaluation datapath: gate-level and logic-level implementations of tables 1–4, muxed externally by `sel`. It drives each row, waits a settle time and samples both outputs. It builds the captured truth vector and counts gate-vs-logic mismatches. It sits between the lab's board controls (switch/button) and the combinational table modules, turning one start press into a full self-check.

---
 rtl/tabla_scan_ctrl.sv | 158 +++++++++++++++
 tb/tb_tabla_scan_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tabla_scan_ctrl.sv
// rtl/tabla_scan_ctrl.sv - truth-table sweep sequencer with gate-vs-logic mismatch counting
// Optional first-mismatch capture is built when TABLA_FIRST_FAIL_EN is defined.
module tabla_scan_ctrl #(
   parameter int unsigned SETTLE = 1
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_start,
   input  logic        i_abort,
   input  logic [1:0]  i_tabla,
   input  logic        i_nvars,
   input  logic        i_y_gate,
   input  logic        i_y_logic,
   output logic [1:0]  o_sel,
   output logic [3:0]  o_abcd,
   output logic        o_busy,
   output logic        o_done,
   output logic [15:0] o_truth,
   output logic [4:0]  o_err_cnt,
   output logic        o_pass,
   output logic [3:0]  o_first_fail,
   output logic        o_fail_seen
);

   localparam logic [3:0] LP_SETTLE = 4'(SETTLE);

   typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [3:0]  r_row;
   logic [3:0]  r_wait;
   logic        r_nvars;
   logic [1:0]  r_sel;
   logic [3:0]  r_abcd;
   logic        r_busy;
   logic        r_done;
   logic [15:0] r_truth;
   logic [4:0]  r_err_cnt;
   logic        r_pass;

   logic        w_accept;
   logic        w_sample;
   logic        w_last;
   logic        w_mismatch;
   logic [3:0]  w_row_nxt;
   logic        w_nvars_nxt;
   logic [4:0]  w_err_nxt;
   logic [3:0]  w_abcd_nxt;

   assign w_accept   = (r_state == S_IDLE) && i_start;
   assign w_sample   = (r_state == S_DRIVE) && !i_abort && (r_wait == 4'd0);
   assign w_last     = r_nvars ? (r_row == 4'd15) : (r_row == 4'd7);
   assign w_mismatch = i_y_gate != i_y_logic;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_state_nxt = S_DRIVE;
         S_DRIVE: begin
            if (i_abort)               w_state_nxt = S_IDLE;
            else if (w_sample && w_last) w_state_nxt = S_DONE;
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // 3-variable mode places {A,B,C} on abcd[3:1] and holds D low
   always_comb begin
      w_row_nxt   = r_row;
      w_nvars_nxt = r_nvars;
      w_err_nxt   = r_err_cnt;
      if (w_accept) begin
         w_row_nxt   = 4'd0;
         w_nvars_nxt = i_nvars;
         w_err_nxt   = 5'd0;
      end else if (w_sample) begin
         if (!w_last)    w_row_nxt = r_row + 4'd1;
         if (w_mismatch) w_err_nxt = r_err_cnt + 5'd1;
      end
      w_abcd_nxt = 4'd0;
      if (w_state_nxt == S_DRIVE)
         w_abcd_nxt = w_nvars_nxt ? w_row_nxt : {w_row_nxt[2:0], 1'b0};
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_row     <= 4'd0;
         r_wait    <= 4'd0;
         r_nvars   <= 1'b0;
         r_sel     <= 2'd0;
         r_abcd    <= 4'd0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_truth   <= 16'd0;
         r_err_cnt <= 5'd0;
         r_pass    <= 1'b0;
      end else begin
         r_row     <= w_row_nxt;
         r_nvars   <= w_nvars_nxt;
         r_err_cnt <= w_err_nxt;
         r_abcd    <= w_abcd_nxt;
         r_busy    <= (w_state_nxt != S_IDLE);
         r_done    <= (w_state_nxt == S_DONE);
         if (w_accept) begin
            r_sel   <= i_tabla;
            r_truth <= 16'd0;
            r_pass  <= 1'b0;
            r_wait  <= LP_SETTLE;
         end else if (w_sample) begin
            r_truth[r_row] <= i_y_gate;
            r_wait         <= LP_SETTLE;
            if (w_last) r_pass <= (w_err_nxt == 5'd0);
         end else if (r_state == S_DRIVE && !i_abort) begin
            r_wait <= r_wait - 4'd1;
         end
      end
   end

`ifdef TABLA_FIRST_FAIL_EN
   logic [3:0] r_first_fail;
   logic       r_fail_seen;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_first_fail <= 4'd0;
         r_fail_seen  <= 1'b0;
      end else if (w_accept) begin
         r_first_fail <= 4'd0;
         r_fail_seen  <= 1'b0;
      end else if (w_sample && w_mismatch && !r_fail_seen) begin
         r_first_fail <= r_row;
         r_fail_seen  <= 1'b1;
      end
   end

   assign o_first_fail = r_first_fail;
   assign o_fail_seen  = r_fail_seen;
`else
   assign o_first_fail = 4'd0;
   assign o_fail_seen  = 1'b0;
`endif

   assign o_sel     = r_sel;
   assign o_abcd    = r_abcd;
   assign o_busy    = r_busy;
   assign o_done    = r_done;
   assign o_truth   = r_truth;
   assign o_err_cnt = r_err_cnt;
   assign o_pass    = r_pass;

endmodule

// File: tb/tb_tabla_scan_ctrl.sv
// tb/tb_tabla_scan_ctrl.sv - self-checking bench for tabla_scan_ctrl (instances with SETTLE=0 and SETTLE=1)
module tb_tabla_scan_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [1:0]  tabla;
   logic        nvars;
   logic        start_i [2];
   logic        abort_i [2];
   logic        yg [2];
   logic        yl [2];
   logic [1:0]  sel_o [2];
   logic [3:0]  abcd_o [2];
   logic        busy_o [2];
   logic        done_o [2];
   logic [15:0] truth_o [2];
   logic [4:0]  err_o [2];
   logic        pass_o [2];
   logic [3:0]  ff_o [2];
   logic        fs_o [2];

   // per-instance table contents: gate output per row, and rows where logic disagrees
   logic [15:0] pat [2];
   logic [15:0] mm [2];

   int n_vec = 0;
   int n_err = 0;

   function automatic logic [3:0] row_of(input logic [3:0] a, input logic nv);
      return nv ? a : {1'b0, a[3:1]};
   endfunction

   assign yg[0] = pat[0][row_of(abcd_o[0], nvars)];
   assign yl[0] = pat[0][row_of(abcd_o[0], nvars)] ^ mm[0][row_of(abcd_o[0], nvars)];
   assign yg[1] = pat[1][row_of(abcd_o[1], nvars)];
   assign yl[1] = pat[1][row_of(abcd_o[1], nvars)] ^ mm[1][row_of(abcd_o[1], nvars)];

   tabla_scan_ctrl #(.SETTLE(0)) u_dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start_i[0]), .i_abort(abort_i[0]),
      .i_tabla(tabla), .i_nvars(nvars), .i_y_gate(yg[0]), .i_y_logic(yl[0]),
      .o_sel(sel_o[0]), .o_abcd(abcd_o[0]), .o_busy(busy_o[0]), .o_done(done_o[0]),
      .o_truth(truth_o[0]), .o_err_cnt(err_o[0]), .o_pass(pass_o[0]),
      .o_first_fail(ff_o[0]), .o_fail_seen(fs_o[0]));

   tabla_scan_ctrl #(.SETTLE(1)) u_dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start_i[1]), .i_abort(abort_i[1]),
      .i_tabla(tabla), .i_nvars(nvars), .i_y_gate(yg[1]), .i_y_logic(yl[1]),
      .o_sel(sel_o[1]), .o_abcd(abcd_o[1]), .o_busy(busy_o[1]), .o_done(done_o[1]),
      .o_truth(truth_o[1]), .o_err_cnt(err_o[1]), .o_pass(pass_o[1]),
      .o_first_fail(ff_o[1]), .o_fail_seen(fs_o[1]));

   // reference model: results of a complete sweep from the table contents alone
   function automatic logic [15:0] row_mask(input logic nv);
      return nv ? 16'hFFFF : 16'h00FF;
   endfunction

   function automatic logic [4:0] exp_err(input logic [15:0] m, input logic nv);
      return 5'($countones(m & row_mask(nv)));
   endfunction

   function automatic logic [4:0] exp_first(input logic [15:0] m, input logic nv);
      logic [15:0] v;
      v = m & row_mask(nv);
`ifdef TABLA_FIRST_FAIL_EN
      for (int i = 0; i < 16; i++)
         if (v[i]) return {1'b1, 4'(i)};
`endif
      return 5'd0;
   endfunction

   // runs one sweep on instance k; reports the done cycle and cycles whose abcd/busy/done differ from the schedule
   task automatic sweep(input int k, input logic [1:0] tab, input logic nv,
                        output int done_cyc, output int seq_bad);
      int rows, len, row;
      logic [3:0] e_abcd;
      rows = nv ? 16 : 8;
      len  = rows * (k + 1) + 1;
      done_cyc = -1;
      seq_bad  = 0;
      @(negedge clk);
      tabla = tab; nvars = nv; start_i[k] = 1'b1;
      @(negedge clk);
      start_i[k] = 1'b0;
      for (int c = 1; c <= len + 3; c++) begin
         if (c > 1) @(negedge clk);
         row    = (c - 1) / (k + 1);
         e_abcd = (c < len) ? (nv ? 4'(row) : 4'(row << 1)) : 4'd0;
         if (done_o[k] === 1'b1 && done_cyc < 0) done_cyc = c;
         if (done_o[k] !== (c == len)) seq_bad++;
         if (busy_o[k] !== (c <= len)) seq_bad++;
         if (abcd_o[k] !== e_abcd) seq_bad++;
      end
   endtask

   task automatic check_results(input string nm, input int k, input logic [1:0] tab, input logic nv,
                                input int done_cyc, input int seq_bad);
      logic [4:0] e_ff;
      n_vec++;
      if (done_cyc !== (nv ? 16 : 8) * (k + 1) + 1) begin
         n_err++; $display("FAIL %s done_cycle got=%0d exp=%0d", nm, done_cyc, (nv ? 16 : 8) * (k + 1) + 1);
      end
      n_vec++;
      if (seq_bad !== 0) begin
         n_err++; $display("FAIL %s sequence got=%0d bad cycles exp=0", nm, seq_bad);
      end
      n_vec++;
      if (truth_o[k] !== (pat[k] & row_mask(nv))) begin
         n_err++; $display("FAIL %s truth got=%h exp=%h", nm, truth_o[k], pat[k] & row_mask(nv));
      end
      n_vec++;
      if (err_o[k] !== exp_err(mm[k], nv)) begin
         n_err++; $display("FAIL %s err_cnt got=%0d exp=%0d", nm, err_o[k], exp_err(mm[k], nv));
      end
      n_vec++;
      if (pass_o[k] !== (exp_err(mm[k], nv) == 0)) begin
         n_err++; $display("FAIL %s pass got=%b exp=%b", nm, pass_o[k], exp_err(mm[k], nv) == 0);
      end
      n_vec++;
      if (sel_o[k] !== tab) begin
         n_err++; $display("FAIL %s sel got=%0d exp=%0d", nm, sel_o[k], tab);
      end
      e_ff = exp_first(mm[k], nv);
      n_vec++;
      if ({fs_o[k], ff_o[k]} !== e_ff) begin
         n_err++; $display("FAIL %s first_fail got=%b/%0d exp=%b/%0d", nm, fs_o[k], ff_o[k], e_ff[4], e_ff[3:0]);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         start_i[0] = ~start_i[0];
         start_i[1] = ~start_i[1];
      end
      start_i[0] = 1'b0; start_i[1] = 1'b0;
      for (int k = 0; k < 2; k++) begin
         n_vec++;
         if ({sel_o[k], abcd_o[k], busy_o[k], done_o[k], truth_o[k], err_o[k], pass_o[k], ff_o[k], fs_o[k]} !== 36'd0) begin
            n_err++; $display("FAIL reset_values inst%0d got busy=%b abcd=%h truth=%h err=%0d", k, busy_o[k], abcd_o[k], truth_o[k], err_o[k]);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         n_vec++;
         if ({busy_o[k], abcd_o[k], done_o[k]} !== 6'd0) begin
            n_err++; $display("FAIL reset_idle inst%0d got busy=%b abcd=%h done=%b exp 0", k, busy_o[k], abcd_o[k], done_o[k]);
         end
      end
   endtask

   task automatic test_table1();
      int dc, sb;
      for (int r = 0; r < 16; r++) pat[1][r] = (r < 8) ? ~r[1] : 1'b0;
      mm[1] = 16'h0000;
      sweep(1, 2'd1, 1'b0, dc, sb);
      check_results("table1", 1, 2'd1, 1'b0, dc, sb);
      n_vec++;
      if (truth_o[1] !== 16'h0033) begin
         n_err++; $display("FAIL table1_literal truth got=%h exp=0033", truth_o[1]);
      end
   endtask

   task automatic test_mismatch();
      int dc, sb;
      pat[0] = 16'($urandom);
      mm[0]  = 16'h1020;
      sweep(0, 2'($urandom), 1'b1, dc, sb);
      check_results("mismatch", 0, tabla, 1'b1, dc, sb);
      n_vec++;
      if (err_o[0] !== 5'd2 || pass_o[0] !== 1'b0) begin
         n_err++; $display("FAIL mismatch_literal err=%0d pass=%b exp 2/0", err_o[0], pass_o[0]);
      end
   endtask

   task automatic test_restart_abort();
      int budget, dones;
      pat[1] = 16'($urandom);
      mm[1]  = 16'($urandom) & 16'($urandom);
      @(negedge clk);
      tabla = 2'($urandom); nvars = 1'b1; start_i[1] = 1'b1;
      @(negedge clk);
      start_i[1] = 1'b0;
      budget = 0;
      while (abcd_o[1] !== 4'd3 && budget < 40) begin @(negedge clk); budget++; end
      start_i[1] = 1'b1;
      @(negedge clk);
      start_i[1] = 1'b0;
      n_vec++;
      if (abcd_o[1] !== 4'd3 || busy_o[1] !== 1'b1) begin
         n_err++; $display("FAIL no_restart abcd=%0d busy=%b exp 3/1", abcd_o[1], busy_o[1]);
      end
      budget = 0;
      while (abcd_o[1] !== 4'd6 && budget < 40) begin @(negedge clk); budget++; end
      n_vec++;
      if (budget >= 40) begin
         n_err++; $display("FAIL abort_reach_row6 timeout abcd=%0d", abcd_o[1]);
      end
      abort_i[1] = 1'b1;
      @(negedge clk);
      abort_i[1] = 1'b0;
      n_vec++;
      if (busy_o[1] !== 1'b0 || abcd_o[1] !== 4'd0 || done_o[1] !== 1'b0) begin
         n_err++; $display("FAIL abort_idle busy=%b abcd=%0d done=%b exp 0/0/0", busy_o[1], abcd_o[1], done_o[1]);
      end
      n_vec++;
      if (truth_o[1] !== (pat[1] & 16'h003F) || err_o[1] !== exp_err(mm[1] & 16'h003F, 1'b1) || pass_o[1] !== 1'b0) begin
         n_err++; $display("FAIL abort_partial truth=%h err=%0d pass=%b exp %h/%0d/0", truth_o[1], err_o[1], pass_o[1],
                           pat[1] & 16'h003F, exp_err(mm[1] & 16'h003F, 1'b1));
      end
      dones = 0;
      repeat (20) begin @(negedge clk); if (done_o[1] === 1'b1) dones++; end
      n_vec++;
      if (dones !== 0) begin
         n_err++; $display("FAIL abort_no_done got=%0d pulses exp=0", dones);
      end
   endtask

   task automatic test_reset_mid();
      int budget, dc, sb;
      pat[0] = 16'($urandom);
      mm[0]  = 16'($urandom) & 16'($urandom);
      @(negedge clk);
      tabla = 2'($urandom); nvars = 1'b1; start_i[0] = 1'b1;
      @(negedge clk);
      start_i[0] = 1'b0;
      budget = 0;
      while (abcd_o[0] !== 4'd9 && budget < 40) begin @(negedge clk); budget++; end
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({sel_o[0], abcd_o[0], busy_o[0], done_o[0], truth_o[0], err_o[0], pass_o[0], ff_o[0], fs_o[0]} !== 36'd0) begin
         n_err++; $display("FAIL reset_mid busy=%b abcd=%h truth=%h err=%0d exp all 0", busy_o[0], abcd_o[0], truth_o[0], err_o[0]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      n_vec++;
      if (done_o[0] !== 1'b0 || busy_o[0] !== 1'b0) begin
         n_err++; $display("FAIL reset_mid_quiet done=%b busy=%b exp 0/0", done_o[0], busy_o[0]);
      end
      sweep(0, 2'($urandom), 1'($urandom), dc, sb);
      check_results("after_reset", 0, tabla, nvars, dc, sb);
   endtask

   task automatic test_random();
      int dc, sb, k;
      for (int i = 0; i < 8; i++) begin
         k = i % 2;
         pat[k] = 16'($urandom);
         mm[k]  = 16'($urandom) & 16'($urandom) & ((i == 2) ? 16'h0000 : 16'hFFFF);
         sweep(k, 2'($urandom), 1'($urandom), dc, sb);
         check_results("random", k, tabla, nvars, dc, sb);
      end
   endtask

   initial begin
      rst_n = 1'b0; tabla = 2'd0; nvars = 1'b0;
      start_i[0] = 1'b0; start_i[1] = 1'b0;
      abort_i[0] = 1'b0; abort_i[1] = 1'b0;
      pat[0] = 16'd0; pat[1] = 16'd0; mm[0] = 16'd0; mm[1] = 16'd0;
      test_reset();
      test_table1();
      test_mismatch();
      test_restart_abort();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
